// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: exception codes, stall masks,
// STOP/NOSTOP levels, the zero word, FSM state type and the stall priority
// encoder. Every pipeline register imports this package.
package pipe_ctrl_pkg;

  localparam logic        STOP      = 1'b1;
  localparam logic        NOSTOP    = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // MEM-stage exception codes
  localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INV     = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  // stall[5:0] = {WB, MEM, EX, ID, IF, PC}; a requester freezes itself and
  // everything upstream, the stage below it takes a bubble.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } state_t;

  typedef struct packed {
    logic mem;
    logic ex;
    logic id;
    logic fetch;
  } stall_req_t;

  // Deepest requester wins; its mask already covers all upstream stages.
  function automatic logic [5:0] stall_encode(input stall_req_t r);
    if (r.mem)        return STALL_MEM;
    else if (r.ex)    return STALL_EX;
    else if (r.id)    return STALL_ID;
    else if (r.fetch) return STALL_IF;
    else              return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive stalled cycles and raises a sticky flag
// once STALL_TIMEOUT of them have elapsed back to back.
//   clk, rst   : clock, async active-high reset
//   stalled    : 1 when the pipeline is stalled this cycle (flush cycles are 0)
//   wd_timeout : sticky trip flag, cleared only by rst
module stall_watchdog
  #(parameter int STALL_TIMEOUT = 1024,
    parameter int WD_W          = 11)
  (input  logic clk,
   input  logic rst,
   input  logic stalled,
   output logic wd_timeout);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(STALL_TIMEOUT);

  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] cnt_inc;

  // Saturate at all-ones so a long stall never wraps back to a small count.
  assign cnt_inc = (wd_cnt == '1) ? wd_cnt : wd_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt     <= '0;
      wd_timeout <= 1'b0;
    end else begin
      wd_cnt <= stalled ? cnt_inc : '0;
      // Trip on the edge that closes the STALL_TIMEOUT-th stalled cycle.
      if (stalled && cnt_inc >= LIMIT) wd_timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control for the 5-stage core. Merges stall requests
// into the stall vector, turns MEM-stage exceptions into a one-cycle flush
// with a redirect PC, and keeps a stall counter and a stall watchdog.
//   clk, rst            : clock, async active-high reset
//   stallreq_from_*     : per-stage stall requests (if/id/ex/mem)
//   excepttype_i        : MEM exception code, 0 = none
//   cp0_epc_i           : EPC used as redirect target for eret
//   stall[5:0]          : {WB,MEM,EX,ID,IF,PC}, 1 = STOP (combinational)
//   flush, new_pc       : flush pulse and redirect PC (combinational)
//   stall_cnt           : stalled cycles since reset, wraps
//   wd_timeout          : sticky watchdog flag
module pipe_ctrl
  import pipe_ctrl_pkg::*;
  #(parameter logic [31:0] EXC_VECTOR    = 32'h0000_0040,
    parameter int          STALL_TIMEOUT = 1024,
    parameter int          WD_W          = 11)
  (input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_if,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cnt,
   output logic        wd_timeout);

  state_t     state, state_nxt;
  stall_req_t req;

  assign req = '{mem: stallreq_from_mem, ex: stallreq_from_ex,
                 id: stallreq_from_id, fetch: stallreq_from_if};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    stall     = STALL_NONE;
    flush     = NOSTOP;
    new_pc    = ZERO_WORD;
    state_nxt = ST_RUN;
    unique case (state)
      ST_RUN: begin
        if (excepttype_i != EXC_NONE) begin
          // Flush beats every stall request.
          flush     = STOP;
          new_pc    = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
          state_nxt = ST_SHADOW;
        end else begin
          stall = stall_encode(req);
        end
      end
      ST_SHADOW: begin
        // MEM holds the flushed bubble; any code seen here is stale.
        stall     = stall_encode(req);
        state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
    // Outputs are combinational, so mask them while reset is held.
    if (rst) begin
      stall  = STALL_NONE;
      flush  = NOSTOP;
      new_pc = ZERO_WORD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      stall_cnt <= '0;
    else if (stall != STALL_NONE) stall_cnt <= stall_cnt + 32'd1;
  end

  stall_watchdog #(.STALL_TIMEOUT(STALL_TIMEOUT), .WD_W(WD_W)) u_wd (
    .clk        (clk),
    .rst        (rst),
    .stalled    (stall != STALL_NONE),
    .wd_timeout (wd_timeout)
  );

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the 5-stage core. It collects stall requests from IF/ID/EX/MEM and exception status from MEM, and drives the `stall[5:0]` vector and `flush` pulse consumed by every pipeline register (pc_reg, if_id, id_ex, ex_mem, mem_wb), plus the redirect PC for flushes. It also holds a post-flush shadow state machine, a stall watchdog and a stall performance counter.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h0000_0040: redirect target for all exceptions except eret.
- `STALL_TIMEOUT`, 1024: number of consecutive stalled cycles that trips the watchdog.
- `WD_W`, 11: watchdog counter width; must satisfy 2^WD_W > STALL_TIMEOUT.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stallreq_from_if` in 1: instruction fetch not ready.
- `stallreq_from_id` in 1: load-use hazard.
- `stallreq_from_ex` in 1: multi-cycle ALU op (mult/div) busy.
- `stallreq_from_mem` in 1: data access not ready.
- `excepttype_i` in 32: MEM-stage exception code; 0 means none.
- `cp0_epc_i` in 32: current EPC from CP0.
- `stall` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = STOP.
- `flush` out 1: flush all pipeline registers this cycle.
- `new_pc` out 32: PC to load when `flush`=1; 0 otherwise.
- `stall_cnt` out 32: total stalled cycles since reset.
- `wd_timeout` out 1: sticky watchdog trip flag.

## Operation
- Stall encoding, highest-priority requester wins: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, if -> 6'b000011, none -> 6'b000000. WB never stalls.
- Exception codes are shared constants: interrupt 32'h1, syscall 32'h8, invalid inst 32'ha, overflow 32'hc, trap 32'hd, eret 32'he.
- FSM states:
  - RUN: stall from the requests; if `excepttype_i`!=0 then `flush`=1, `stall`=0, `new_pc`=`cp0_epc_i` for eret, else `EXC_VECTOR`; next state SHADOW.
  - SHADOW: exactly one cycle; `flush`=0, `stall` from the requests; `excepttype_i` is ignored because MEM holds a bubble; next state RUN.
- Flush overrides all stall requests in the same cycle.
- `stall_cnt` increments every cycle `stall`!=0 and wraps at 2^32.
- Watchdog (`wd_cnt`, WD_W bits): increments while `stall`!=0 and resets to 0 on any cycle with `stall`=0 or `flush`=1. Saturates at all-ones. When it reaches `STALL_TIMEOUT`, `wd_timeout` sets and stays set until reset.
- Reset values: state RUN, `stall`=0, `flush`=0, `new_pc`=0, `stall_cnt`=0, `wd_cnt`=0, `wd_timeout`=0. Reset mid-stall or mid-flush returns everything to these values immediately (asynchronous reset).

## Timing
- `stall`, `flush` and `new_pc` are combinational from the inputs and the state, so consumers act at the same rising edge. Zero-cycle latency is required, e.g. mem_wb inserts a bubble when stall[4]=1 and stall[5]=0.
- State, `stall_cnt`, `wd_cnt` and `wd_timeout` update on the rising edge. `wd_timeout` rises at the edge that ends the STALL_TIMEOUT-th consecutive stalled cycle.
- Back-to-back exceptions are separated by at least one SHADOW cycle; a code present in SHADOW is dropped, not deferred.

## Structure
- Exception codes, stall masks, STOP/NOSTOP and ZeroWord belong in the shared defines header used by all pipeline registers.
- One natural sub-module: `stall_watchdog` (saturating counter, threshold compare, sticky flag). The FSM and priority encoder stay in pipe_ctrl.

## Test plan
- Reset with all requests high -> `stall`=0, `flush`=0, `new_pc`=0, counters 0 until `rst` falls. Then `stall`=6'b011111.
- `stallreq_from_id`=1 and `stallreq_from_ex`=1 for 3 cycles -> `stall`=6'b001111 each cycle. `stall_cnt` 0 -> 3. `wd_cnt` resets on the first idle cycle.
- `excepttype_i`=32'hc in RUN with `stallreq_from_mem`=1 -> `flush`=1, `stall`=0, `new_pc`=32'h40. Next cycle (SHADOW) `flush`=0 and `stall`=6'b011111.
- `excepttype_i`=32'he, `cp0_epc_i`=32'hbfc0_0100 -> `new_pc`=32'hbfc0_0100 for one cycle. The same code held in the following cycle produces no flush.
- `STALL_TIMEOUT`=8, `stallreq_from_if` held for 10 cycles -> `wd_timeout` rises after the 8th stalled cycle. It stays high after the request drops and clears only on `rst`.
- Assert `rst` during SHADOW while stalled -> all outputs return to their reset values immediately. The first cycle after release is RUN.
